// File: rtl/counter_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_monitor_pkg
// Brief    : Shared types and defaults for the up/down counter step monitor.
// Revision : 1.0  initial release
// ============================================================================
package counter_monitor_pkg;

    localparam int C_DEF_WIDTH = 4;
    localparam int C_DEF_ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAULT = 2'd3
    } mon_state_t;

endpackage : counter_monitor_pkg
`default_nettype wire

// File: rtl/counter_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_monitor_if
// Brief    : Observation inputs and report outputs of the counter step monitor.
// Revision : 1.0  initial release
// ============================================================================
interface counter_monitor_if
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int ERR_W = C_DEF_ERR_W
) ();

    logic             chk_en;
    logic             up_down;
    logic [WIDTH-1:0] count;

    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic             wrap_up;
    logic             wrap_down;
    logic [WIDTH-1:0] expected;
    logic             checking;

    // master: the side that drives the observed counter signals
    modport master (
        output chk_en, up_down, count,
        input  err_pulse, err_sticky, err_count, wrap_up, wrap_down, expected, checking
    );

    modport slave (
        input  chk_en, up_down, count,
        output err_pulse, err_sticky, err_count, wrap_up, wrap_down, expected, checking
    );

endinterface : counter_monitor_if
`default_nettype wire

// File: rtl/counter_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : W-bit up counter that stops at its all-ones value instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         inc,
    output      logic [W-1:0] q
);

    localparam logic [W-1:0] C_MAX = {W{1'b1}};
    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && (r_q != C_MAX)) begin
            r_q <= r_q + C_ONE;
        end
    end

    assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : counter_monitor
// Brief    : Checks that an observed up/down counter moves exactly +/-1 per clock,
//            reporting mismatches, legal wraps and a saturating error tally.
// Revision : 1.0  initial release
// ============================================================================
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH       = C_DEF_WIDTH,
    parameter int ERR_W       = C_DEF_ERR_W,
    parameter int STOP_ON_ERR = 0
) (
    input wire logic        clk,
    input wire logic        reset,
    counter_monitor_if.slave mon
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_expected;
    logic             r_prev_dir;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic             r_wrap_up;
    logic             r_wrap_down;
    logic [ERR_W-1:0] w_err_count;

    logic             w_compare;
    logic             w_mismatch;
    logic             w_match;
    logic             w_ref_load;
    logic             w_fault_go;
    logic [WIDTH-1:0] w_next_exp;

    // Only a sample taken while armed in CHECK is judged; the leaving edge is not.
    assign w_compare  = (r_state == CHECK) && mon.chk_en;
    assign w_mismatch = w_compare && (mon.count != r_expected);
    assign w_match    = w_compare && (mon.count == r_expected);
    assign w_ref_load = (r_state == SYNC) || (r_state == CHECK);
    assign w_next_exp = mon.up_down ? (mon.count + C_ONE) : (mon.count - C_ONE);

    generate
        if (STOP_ON_ERR != 0) begin : g_stop_on_err
            assign w_fault_go = w_mismatch;
        end else begin : g_keep_checking
            assign w_fault_go = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mon.chk_en) begin
                    w_state_nxt = SYNC;
                end
            end
            SYNC: begin
                w_state_nxt = mon.chk_en ? CHECK : IDLE;
            end
            CHECK: begin
                if (!mon.chk_en) begin
                    w_state_nxt = IDLE;
                end else if (w_fault_go) begin
                    w_state_nxt = FAULT;
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The reference always follows the observed count, so a single glitch
    // produces one error and the following step is judged from the actual value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected   <= '0;
            r_prev_dir   <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_wrap_up    <= 1'b0;
            r_wrap_down  <= 1'b0;
        end else begin
            r_err_pulse <= w_mismatch;
            r_wrap_up   <= w_match && r_prev_dir && (mon.count == '0);
            r_wrap_down <= w_match && !r_prev_dir && (mon.count == C_MAX);
            if (w_mismatch) begin
                r_err_sticky <= 1'b1;
            end
            if (w_ref_load) begin
                r_expected <= w_next_exp;
                r_prev_dir <= mon.up_down;
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_tally (
        .clk   (clk),
        .reset (reset),
        .inc   (w_mismatch),
        .q     (w_err_count)
    );

    assign mon.err_pulse  = r_err_pulse;
    assign mon.err_sticky = r_err_sticky;
    assign mon.err_count  = w_err_count;
    assign mon.wrap_up    = r_wrap_up;
    assign mon.wrap_down  = r_wrap_down;
    assign mon.expected   = r_expected;
    assign mon.checking   = (r_state == CHECK);

endmodule : counter_monitor
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_monitor
// Brief    : Scoreboard bench running three monitor configurations side by side.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_monitor;

    typedef struct {
        int pulse;
        int sticky;
        int cnt;
        int wu;
        int wd;
        int expv;
        int chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       chk_en_v;
    logic       up_down_v;
    logic [3:0] count_v;

    always #5 clk = ~clk;

    counter_monitor_if #(.WIDTH(4), .ERR_W(8)) if0 ();
    counter_monitor_if #(.WIDTH(4), .ERR_W(2)) if1 ();
    counter_monitor_if #(.WIDTH(4), .ERR_W(8)) if2 ();

    assign if0.chk_en = chk_en_v;  assign if0.up_down = up_down_v;  assign if0.count = count_v;
    assign if1.chk_en = chk_en_v;  assign if1.up_down = up_down_v;  assign if1.count = count_v;
    assign if2.chk_en = chk_en_v;  assign if2.up_down = up_down_v;  assign if2.count = count_v;

    counter_monitor #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(0)) u_dut0 (.clk(clk), .reset(reset), .mon(if0));
    counter_monitor #(.WIDTH(4), .ERR_W(2), .STOP_ON_ERR(0)) u_dut1 (.clk(clk), .reset(reset), .mon(if1));
    counter_monitor #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1)) u_dut2 (.clk(clk), .reset(reset), .mon(if2));

    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // reference model state, one slot per configuration (0 idle,1 sync,2 check,3 fault)
    int cfg_max[3]  = '{255, 3, 255};
    int cfg_stop[3] = '{0, 0, 1};
    int m_state[3], m_prev_cnt[3], m_prev_dir[3], m_has_ref[3];
    int m_sticky[3], m_cnt[3], m_pulse[3], m_wu[3], m_wd[3];

    int c      = 3;
    bit en_v   = 1'b0;
    int n_wu   = 0;
    int n_wd   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit en, input bit ud, input int cnt);
        int want;
        m_pulse[i] = 0; m_wu[i] = 0; m_wd[i] = 0;
        if (rst) begin
            m_state[i] = 0; m_has_ref[i] = 0; m_prev_cnt[i] = 0; m_prev_dir[i] = 0;
            m_sticky[i] = 0; m_cnt[i] = 0;
            return;
        end
        case (m_state[i])
            0: if (en) m_state[i] = 1;
            1: begin
                m_prev_cnt[i] = cnt; m_prev_dir[i] = ud; m_has_ref[i] = 1;
                m_state[i] = en ? 2 : 0;
            end
            2: begin
                if (en) begin
                    want = (m_prev_dir[i] != 0) ? (m_prev_cnt[i] + 1) % 16 : (m_prev_cnt[i] + 15) % 16;
                    if (cnt != want) begin
                        m_pulse[i] = 1; m_sticky[i] = 1;
                        if (m_cnt[i] < cfg_max[i]) m_cnt[i]++;
                        if (cfg_stop[i] != 0) m_state[i] = 3;
                    end else begin
                        m_wu[i] = (m_prev_dir[i] != 0 && m_prev_cnt[i] == 15) ? 1 : 0;
                        m_wd[i] = (m_prev_dir[i] == 0 && m_prev_cnt[i] == 0) ? 1 : 0;
                    end
                end else begin
                    m_state[i] = 0;
                end
                m_prev_cnt[i] = cnt; m_prev_dir[i] = ud;
            end
            default: ;
        endcase
    endtask

    task automatic compare_one(input string nm, input int p, input int s, input int n,
                               input int wu, input int wd, input int e, input int ch);
        exp_t x;
        if (sb_q.size() == 0) begin
            check_eq({nm, ".sb_underflow"}, 0, 1);
            return;
        end
        x = sb_q.pop_front();
        check_eq({nm, ".err_pulse"},  p,  x.pulse);
        check_eq({nm, ".err_sticky"}, s,  x.sticky);
        check_eq({nm, ".err_count"},  n,  x.cnt);
        check_eq({nm, ".wrap_up"},    wu, x.wu);
        check_eq({nm, ".wrap_down"},  wd, x.wd);
        check_eq({nm, ".expected"},   e,  x.expv);
        check_eq({nm, ".checking"},   ch, x.chk);
    endtask

    task automatic cycle(input bit rst, input bit en, input bit ud, input int cnt);
        exp_t x;
        @(negedge clk);
        reset = rst; chk_en_v = en; up_down_v = ud; count_v = 4'(cnt);
        for (int i = 0; i < 3; i++) begin
            model_step(i, rst, en, ud, cnt);
            x.pulse  = m_pulse[i];
            x.sticky = m_sticky[i];
            x.cnt    = m_cnt[i];
            x.wu     = m_wu[i];
            x.wd     = m_wd[i];
            x.expv   = (m_has_ref[i] == 0) ? 0 :
                       ((m_prev_dir[i] != 0) ? (m_prev_cnt[i] + 1) % 16 : (m_prev_cnt[i] + 15) % 16);
            x.chk    = (m_state[i] == 2) ? 1 : 0;
            sb_q.push_back(x);
        end
        @(posedge clk);
        #1;
        compare_one("d0", int'(if0.err_pulse), int'(if0.err_sticky), int'(if0.err_count),
                    int'(if0.wrap_up), int'(if0.wrap_down), int'(if0.expected), int'(if0.checking));
        compare_one("d1", int'(if1.err_pulse), int'(if1.err_sticky), int'(if1.err_count),
                    int'(if1.wrap_up), int'(if1.wrap_down), int'(if1.expected), int'(if1.checking));
        compare_one("d2", int'(if2.err_pulse), int'(if2.err_sticky), int'(if2.err_count),
                    int'(if2.wrap_up), int'(if2.wrap_down), int'(if2.expected), int'(if2.checking));
        if (if0.wrap_up)   n_wu++;
        if (if0.wrap_down) n_wd++;
    endtask

    // healthy counter: drive c now, direction dir takes effect on the next value
    task automatic run(input int n, input bit dir);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, en_v, dir, c);
            c = dir ? (c + 1) % 16 : (c + 15) % 16;
        end
    endtask

    // skipped value while counting up, e.g. 5 -> 7
    task automatic glitch();
        cycle(1'b0, en_v, 1'b1, (c + 1) % 16);
        c = (c + 2) % 16;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; chk_en_v = 1'b0; up_down_v = 1'b1; count_v = 4'd0;
        for (int i = 0; i < 3; i++) model_step(i, 1'b1, 1'b0, 1'b0, 0);

        // 1: reset then healthy up-count across 15 -> 0
        cycle(1'b1, 1'b0, 1'b1, c);
        cycle(1'b1, 1'b0, 1'b1, c);
        check_eq("rst.err_count", int'(if0.err_count), 0);
        check_eq("rst.checking",  int'(if0.checking),  0);
        en_v = 1'b1;
        run(18, 1'b1);
        check_eq("t1.wrap_up_count", n_wu, 1);
        check_eq("t1.err_count", int'(if0.err_count), 0);

        // 2: up 8, down 8, then down across 0 -> 15
        run(8, 1'b1);
        run(8, 1'b0);
        n_wd = 0;
        run(8, 1'b0);
        check_eq("t2.wrap_down_count", n_wd, 1);
        check_eq("t2.err_count", int'(if0.err_count), 0);

        // 3: single 5 -> 7 glitch, then 7 -> 8 accepted
        for (int k = 0; k < 20 && c != 6; k++) run(1, 1'b1);
        glitch();
        check_eq("t3.err_pulse", int'(if0.err_pulse), 1);
        check_eq("t4.stop_checking", int'(if2.checking), 0);
        run(1, 1'b1);
        check_eq("t3.err_pulse_after", int'(if0.err_pulse), 0);
        check_eq("t3.err_sticky", int'(if0.err_sticky), 1);
        check_eq("t3.err_count", int'(if0.err_count), 1);

        // 4: four more mismatches; narrow tally saturates, stop variant frozen
        for (int g = 0; g < 4; g++) begin
            glitch();
            run(2, 1'b1);
        end
        check_eq("t4.d0_count", int'(if0.err_count), 5);
        check_eq("t4.d1_sat",   int'(if1.err_count), 3);
        check_eq("t4.d2_frozen", int'(if2.err_count), 1);

        // 5: reset mid-check with two errors, chk_en drop, re-arm after a jump
        cycle(1'b1, 1'b0, 1'b1, c);
        c = (c + 1) % 16;
        run(4, 1'b1);
        glitch();
        run(2, 1'b1);
        glitch();
        run(2, 1'b1);
        check_eq("t5.pre_reset_count", int'(if0.err_count), 2);
        cycle(1'b1, 1'b1, 1'b1, c);
        c = (c + 1) % 16;
        check_eq("t5.rst_count",    int'(if0.err_count),  0);
        check_eq("t5.rst_sticky",   int'(if0.err_sticky), 0);
        check_eq("t5.rst_checking", int'(if0.checking),   0);
        check_eq("t5.rst_expected", int'(if0.expected),   0);
        run(6, 1'b1);
        glitch();
        run(2, 1'b1);
        en_v = 1'b0;
        run(3, 1'b1);
        check_eq("t5.held_count", int'(if0.err_count), 1);
        c = (c + 7) % 16;
        run(2, 1'b1);
        en_v = 1'b1;
        run(6, 1'b1);
        check_eq("t5.rearm_count", int'(if0.err_count), 1);
        check_eq("t5.rearm_checking", int'(if0.checking), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_counter_monitor
`default_nettype wire
